// File: rtl/scan_code_display_buffer.sv
// PS/2 scan-code stream to multi-digit seven-segment buffer: strips F0/E0 prefixes,
// shifts letters/space in at digit 0, and handles backspace and escape edits.
module scan_code_display_buffer #(
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int FULL_MODE  = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              scan_code,
  input  logic                    scan_valid,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [4:0]              char_count,
  output logic                    char_valid,
  output logic [4:0]              char_code,
  output logic                    overflow
);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  // Digits are stored already in output polarity, so BLANK is the unlit pattern.
  localparam logic [6:0] BLANK     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [4:0] FULL_CNT  = 5'(NUM_DIGITS);
  localparam logic [4:0] NO_LETTER = 5'd31;

  function automatic logic [4:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: return 5'd0;   8'h32: return 5'd1;   8'h21: return 5'd2;
      8'h23: return 5'd3;   8'h24: return 5'd4;   8'h2B: return 5'd5;
      8'h34: return 5'd6;   8'h33: return 5'd7;   8'h43: return 5'd8;
      8'h3B: return 5'd9;   8'h42: return 5'd10;  8'h4B: return 5'd11;
      8'h3A: return 5'd12;  8'h31: return 5'd13;  8'h44: return 5'd14;
      8'h4D: return 5'd15;  8'h15: return 5'd16;  8'h2D: return 5'd17;
      8'h1B: return 5'd18;  8'h2C: return 5'd19;  8'h3C: return 5'd20;
      8'h2A: return 5'd21;  8'h1D: return 5'd22;  8'h22: return 5'd23;
      8'h35: return 5'd24;  8'h1A: return 5'd25;
      default: return NO_LETTER;
    endcase
  endfunction

  function automatic logic [6:0] letter_glyph(input logic [4:0] idx);
    case (idx)
      5'd0:  return 7'h77;  5'd1:  return 7'h1F;  5'd2:  return 7'h4E;
      5'd3:  return 7'h3D;  5'd4:  return 7'h4F;  5'd5:  return 7'h47;
      5'd6:  return 7'h7B;  5'd7:  return 7'h37;  5'd8:  return 7'h30;
      5'd9:  return 7'h38;  5'd10: return 7'h07;  5'd11: return 7'h0E;
      5'd12: return 7'h54;  5'd13: return 7'h76;  5'd14: return 7'h7E;
      5'd15: return 7'h67;  5'd16: return 7'h73;  5'd17: return 7'h46;
      5'd18: return 7'h5B;  5'd19: return 7'h0F;  5'd20: return 7'h3E;
      5'd21: return 7'h1C;  5'd22: return 7'h2A;  5'd23: return 7'h31;
      5'd24: return 7'h3B;  5'd25: return 7'h6D;
      default: return 7'h00;
    endcase
  endfunction

  state_t     state_q;
  logic [6:0] digit_q [NUM_DIGITS];
  logic [4:0] count_q;
  logic       ovf_q;
  logic       cv_q;
  logic [4:0] cc_q;

  logic [4:0] idx;
  logic       is_letter;
  logic       is_char;
  logic       full;
  logic       accept;
  logic [6:0] new_glyph;

  assign idx       = letter_idx(scan_code);
  assign is_letter = (idx != NO_LETTER);
  assign is_char   = is_letter || (scan_code == 8'h29);
  assign full      = (count_q == FULL_CNT);
  assign accept    = !full || (FULL_MODE == 0);
  assign new_glyph = (is_letter ? letter_glyph(idx) : 7'h00) ^ BLANK;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= BLANK;
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
      cv_q    <= 1'b0;
      cc_q    <= 5'd0;
    end else begin
      cv_q <= 1'b0;
      if (scan_valid) begin
        case (state_q)
          IDLE: begin
            if (scan_code == 8'hF0) begin
              state_q <= BREAK;
            end else if (scan_code == 8'hE0) begin
              state_q <= EXT;
            end else if (is_char) begin
              if (full) ovf_q <= 1'b1;
              if (accept) begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) digit_q[i] <= digit_q[i-1];
                digit_q[0] <= new_glyph;
                if (!full) count_q <= count_q + 5'd1;
                cv_q <= is_letter;
                if (is_letter) cc_q <= idx;
              end
            end else if (scan_code == 8'h66) begin
              if (count_q != 5'd0) begin
                for (int i = 0; i < NUM_DIGITS - 1; i++) digit_q[i] <= digit_q[i+1];
                digit_q[NUM_DIGITS-1] <= BLANK;
                count_q <= count_q - 5'd1;
              end
            end else if (scan_code == 8'h76) begin
              for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= BLANK;
              count_q <= 5'd0;
              ovf_q   <= 1'b0;
            end
          end
          BREAK, EXT_BREAK: state_q <= IDLE;
          EXT:     state_q <= (scan_code == 8'hF0) ? EXT_BREAK : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    assign seg_out[7*g +: 7] = digit_q[g];
  end

  assign char_count = count_q;
  assign char_valid = cv_q;
  assign char_code  = cc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_scan_code_display_buffer.sv
// Scoreboard bench: three configurations share one PS/2 byte stream; a reference
// model queues expected outputs per cycle and a monitor compares after each edge.
module tb_scan_code_display_buffer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        scan_valid = 1'b0;

  logic [55:0] seg_a;
  logic [27:0] seg_b, seg_c;
  logic [4:0]  cnt_a, cnt_b, cnt_c, cc_a, cc_b, cc_c;
  logic        cv_a, cv_b, cv_c, ovf_a, ovf_b, ovf_c;

  scan_code_display_buffer #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .FULL_MODE(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .seg_out(seg_a), .char_count(cnt_a), .char_valid(cv_a), .char_code(cc_a), .overflow(ovf_a));
  scan_code_display_buffer #(.NUM_DIGITS(4), .ACTIVE_LOW(0), .FULL_MODE(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .seg_out(seg_b), .char_count(cnt_b), .char_valid(cv_b), .char_code(cc_b), .overflow(ovf_b));
  scan_code_display_buffer #(.NUM_DIGITS(4), .ACTIVE_LOW(1), .FULL_MODE(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .seg_out(seg_c), .char_count(cnt_c), .char_valid(cv_c), .char_code(cc_c), .overflow(ovf_c));

  typedef struct packed {
    logic [55:0] seg;
    logic [4:0]  cnt;
    logic        cv;
    logic [4:0]  cc;
    logic        ovf;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  int checks = 0;
  int failures = 0;

  int ND  [3] = '{8, 4, 4};
  int ALP [3] = '{1, 0, 1};
  int FMP [3] = '{0, 1, 0};

  logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
                           8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [6:0] GLY [26] = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47, 7'h7B, 7'h37, 7'h30,
                           7'h38, 7'h07, 7'h0E, 7'h54, 7'h76, 7'h7E, 7'h67, 7'h73,
                           7'h46, 7'h5B, 7'h0F, 7'h3E, 7'h1C, 7'h2A, 7'h31, 7'h3B, 7'h6D};

  // Reference model: characters held newest-first, count = occupied digits.
  int  mg  [3][16];
  int  mc  [3];
  bit  mo  [3];
  int  mcc [3];
  bit  mcv [3];
  bit  skip_next = 1'b0;
  bit  after_e0 = 1'b0;

  function automatic int idx_of(logic [7:0] c);
    for (int k = 0; k < 26; k++) if (LET[k] == c) return k;
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic apply_make(int d, logic [7:0] code);
    int li;
    bit full;
    li = idx_of(code);
    if (li >= 0 || code == 8'h29) begin
      full = (mc[d] == ND[d]);
      if (full) mo[d] = 1'b1;
      if (!(full && FMP[d] != 0)) begin
        for (int i = 15; i > 0; i--) mg[d][i] = mg[d][i-1];
        mg[d][0] = (li >= 0) ? int'(GLY[li]) : 0;
        if (!full) mc[d]++;
        if (li >= 0) begin
          mcv[d] = 1'b1;
          mcc[d] = li;
        end
      end
    end else if (code == 8'h66) begin
      if (mc[d] > 0) begin
        for (int i = 0; i < 15; i++) mg[d][i] = mg[d][i+1];
        mc[d]--;
      end
    end else if (code == 8'h76) begin
      mc[d] = 0;
      mo[d] = 1'b0;
    end
  endtask

  task automatic model_step(bit rst_n, bit vld, logic [7:0] code);
    bit make;
    exp_t e;
    make = 1'b0;
    for (int d = 0; d < 3; d++) mcv[d] = 1'b0;
    if (!rst_n) begin
      skip_next = 1'b0;
      after_e0 = 1'b0;
      for (int d = 0; d < 3; d++) begin
        mc[d] = 0; mo[d] = 1'b0; mcc[d] = 0;
      end
    end else if (vld) begin
      if (skip_next) skip_next = 1'b0;
      else if (after_e0) begin
        after_e0 = 1'b0;
        skip_next = (code == 8'hF0);
      end
      else if (code == 8'hF0) skip_next = 1'b1;
      else if (code == 8'hE0) after_e0 = 1'b1;
      else make = 1'b1;
    end
    for (int d = 0; d < 3; d++) begin
      if (make) apply_make(d, code);
      e.seg = '0;
      for (int i = 0; i < ND[d]; i++) begin
        logic [6:0] g;
        g = (i < mc[d]) ? 7'(mg[d][i]) : 7'h00;
        e.seg[7*i +: 7] = (ALP[d] != 0) ? ~g : g;
      end
      e.cnt = 5'(mc[d]);
      e.cv  = mcv[d];
      e.cc  = 5'(mcc[d]);
      e.ovf = mo[d];
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic cyc(bit rst_n, bit vld, logic [7:0] code);
    @(negedge clock);
    reset_n = rst_n;
    scan_valid = vld;
    scan_code = code;
    model_step(rst_n, vld, code);
  endtask

  task automatic send(logic [7:0] code);
    cyc(1'b1, 1'b1, code);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic cmp(int d, exp_t e);
    logic [55:0] s;
    logic [4:0]  c, cc;
    logic        v, o;
    case (d)
      0: begin s = seg_a; c = cnt_a; v = cv_a; cc = cc_a; o = ovf_a; end
      1: begin s = {28'b0, seg_b}; c = cnt_b; v = cv_b; cc = cc_b; o = ovf_b; end
      default: begin s = {28'b0, seg_c}; c = cnt_c; v = cv_c; cc = cc_c; o = ovf_c; end
    endcase
    chk($sformatf("seg_out[dut%0d]", d), 64'(s), 64'(e.seg));
    chk($sformatf("char_count[dut%0d]", d), 64'(c), 64'(e.cnt));
    chk($sformatf("char_valid[dut%0d]", d), 64'(v), 64'(e.cv));
    chk($sformatf("overflow[dut%0d]", d), 64'(o), 64'(e.ovf));
    if (e.cv) chk($sformatf("char_code[dut%0d]", d), 64'(cc), 64'(e.cc));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) cmp(0, q0.pop_front());
      if (q1.size() > 0) cmp(1, q1.pop_front());
      if (q2.size() > 0) cmp(2, q2.pop_front());
    end
  end

  initial begin : driver
    int r;
    logic [7:0] code;

    do_reset(); do_reset(); idle();
    chk("reset seg_a", 64'(seg_a), 64'h00FF_FFFF_FFFF_FFFF);
    chk("reset seg_b", 64'(seg_b), 64'h0);
    chk("reset count", 64'(cnt_a), 64'd0);
    chk("reset char_code", 64'(cc_a), 64'd0);

    send(8'h1C); send(8'h32); idle();
    chk("AB digit0", 64'(seg_a[6:0]), 64'h60);
    chk("AB digit1", 64'(seg_a[13:7]), 64'h08);
    chk("AB count", 64'(cnt_a), 64'd2);

    do_reset(); send(8'h1C); send(8'hF0); send(8'h1C); idle();
    chk("break count", 64'(cnt_a), 64'd1);

    do_reset(); send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C); idle();
    chk("ext count", 64'(cnt_a), 64'd0);

    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24); idle();
    chk("scroll seg", 64'(seg_c), 64'({7'h60, 7'h31, 7'h42, 7'h30}));
    chk("scroll ovf", 64'(ovf_c), 64'd1);
    chk("scroll count", 64'(cnt_c), 64'd4);
    chk("stop seg", 64'(seg_b), 64'({7'h77, 7'h1F, 7'h4E, 7'h3D}));
    chk("stop ovf", 64'(ovf_b), 64'd1);
    send(8'h76); idle();
    chk("esc ovf", 64'(ovf_b), 64'd0);
    chk("esc seg", 64'(seg_b), 64'h0);

    do_reset(); send(8'h1C); send(8'h32); send(8'h66); idle();
    chk("bs1 digit0", 64'(seg_a[6:0]), 64'h08);
    chk("bs1 count", 64'(cnt_a), 64'd1);
    send(8'h66); send(8'h66); idle();
    chk("bs3 count", 64'(cnt_a), 64'd0);
    chk("bs3 seg", 64'(seg_a), 64'h00FF_FFFF_FFFF_FFFF);

    do_reset(); send(8'h1C); send(8'hF0); do_reset(); send(8'h1C); idle();
    chk("rst-break count", 64'(cnt_a), 64'd1);
    chk("rst-break digit0", 64'(seg_a[6:0]), 64'h08);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      code = LET[$urandom_range(0, 25)];
      else if (r < 62) code = 8'h29;
      else if (r < 72) code = 8'h66;
      else if (r < 75) code = 8'h76;
      else if (r < 83) code = 8'hF0;
      else if (r < 88) code = 8'hE0;
      else             code = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), code);
    end

    idle(); idle();
    @(posedge clock); #2;
    chk("scoreboard drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
